// File: rtl/ext_int_conditioner_pkg.sv
// rtl/ext_int_conditioner_pkg.sv - shared constants and channel status type for the external interrupt conditioner
package int_cond_pkg;

  localparam int INT_SYNC_STAGES_DEF     = 2;
  localparam int INT_DEBOUNCE_W_DEF      = 16;
  localparam int INT_DEBOUNCE_CYCLES_DEF = 1000;

  typedef struct packed {
    logic pending;
    logic overrun;
    logic level;
  } int_ch_status_t;

endpackage

// File: rtl/ext_int_conditioner_if.sv
// rtl/ext_int_conditioner_if.sv - pin, enable, clear and status bundle between board pins and the core
interface ext_int_conditioner_if #(
  parameter int NUM_CH = 2
);

  logic [NUM_CH-1:0] int_raw;
  logic [NUM_CH-1:0] edge_rise_en;
  logic [NUM_CH-1:0] edge_fall_en;
  logic [NUM_CH-1:0] int_clr;
  logic [NUM_CH-1:0] int_pending;
  logic [NUM_CH-1:0] int_level;
  logic [NUM_CH-1:0] overrun;

  modport master (
    output int_raw, edge_rise_en, edge_fall_en, int_clr,
    input  int_pending, int_level, overrun
  );

  modport slave (
    input  int_raw, edge_rise_en, edge_fall_en, int_clr,
    output int_pending, int_level, overrun
  );

endinterface

// File: rtl/ext_int_conditioner_debounce.sv
// rtl/ext_int_conditioner_debounce.sv - one channel: pin synchroniser plus debounce filter
// Debounce counter present only when INT_COND_DEBOUNCE_EN is defined.
module int_debounce
  import int_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = INT_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_W      = INT_DEBOUNCE_W_DEF,
  parameter int DEBOUNCE_CYCLES = INT_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  // Illegal configurations elaborate an empty marker block rather than silently misbehaving.
  if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES >= (2 ** DEBOUNCE_W))) begin : g_bad_cfg
  end

`ifdef INT_COND_DEBOUNCE_EN
  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic [DEBOUNCE_W-1:0] cnt;
  logic                  filt_r;

  // A bounce back to the accepted level restarts the count from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_r <= 1'b0;
      cnt    <= '0;
    end else if (sync_o == filt_r) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt_r <= sync_o;
      cnt    <= '0;
    end else begin
      cnt <= cnt + DEBOUNCE_W'(1);
    end
  end

  assign filt = filt_r;
`else
  // Last synchroniser flop doubles as the filtered-level register.
  assign filt = sync_o;
`endif

endmodule

// File: rtl/ext_int_conditioner.sv
// rtl/ext_int_conditioner.sv - external interrupt conditioner top: edge detect, sticky pending and overrun
// Optional debounce filter enabled by defining INT_COND_DEBOUNCE_EN.
module ext_int_conditioner
  import int_cond_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = INT_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_W      = INT_DEBOUNCE_W_DEF,
  parameter int DEBOUNCE_CYCLES = INT_DEBOUNCE_CYCLES_DEF
) (
  input logic                  clk,
  input logic                  reset,
  ext_int_conditioner_if.slave bus
);

  logic [NUM_CH-1:0] filt;
  logic [NUM_CH-1:0] filt_q;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] overrun_q;
  int_ch_status_t    status [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    int_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_W      (DEBOUNCE_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.int_raw[i]),
      .filt  (filt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt;
    end
  end

  assign ev = (filt & ~filt_q & bus.edge_rise_en) | (~filt & filt_q & bus.edge_fall_en);

  // A clear coinciding with a new event consumes the old request but keeps the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ev[i] && bus.int_clr[i]) begin
          pending_q[i] <= 1'b1;
          overrun_q[i] <= 1'b0;
        end else if (ev[i] && pending_q[i]) begin
          overrun_q[i] <= 1'b1;
        end else if (ev[i]) begin
          pending_q[i] <= 1'b1;
        end else if (bus.int_clr[i]) begin
          pending_q[i] <= 1'b0;
          overrun_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      status[i] = '{pending: pending_q[i], overrun: overrun_q[i], level: filt[i]};
    end
  end

  always_comb begin
    bus.int_pending = '0;
    bus.int_level   = '0;
    bus.overrun     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.int_pending[i] = status[i].pending;
      bus.int_level[i]   = status[i].level;
      bus.overrun[i]     = status[i].overrun;
    end
  end

endmodule

// File: tb/tb_ext_int_conditioner.sv
// tb/tb_ext_int_conditioner.sv - directed self-checking bench for ext_int_conditioner
module tb_ext_int_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef INT_COND_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ext_int_conditioner_if #(.NUM_CH(2)) bus ();

  ext_int_conditioner #(
    .NUM_CH          (2),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_W      (16),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear(input logic [1:0] m);
    bus.int_clr = m;
    step(1);
    bus.int_clr = 2'b00;
  endtask

  initial begin
    reset            = 1'b1;
    bus.int_raw      = 2'b00;
    bus.edge_rise_en = 2'b00;
    bus.edge_fall_en = 2'b00;
    bus.int_clr      = 2'b00;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_pending", 32'(bus.int_pending), 32'h0);
    chk("reset_level",   32'(bus.int_level),   32'h0);
    chk("reset_overrun", 32'(bus.overrun),     32'h0);

    // Rising edge latency on ch0, counted edge by edge.
    bus.edge_rise_en = 2'b11;
    bus.int_raw      = 2'b01;
    for (int k = 1; k <= LAT; k++) begin
      step(1);
      chk($sformatf("lat_level_e%0d", k),   32'(bus.int_level[0]),   32'(k >= LAT - 1));
      chk($sformatf("lat_pending_e%0d", k), 32'(bus.int_pending[0]), 32'(k >= LAT));
    end
    chk("lat_ch1_quiet", 32'(bus.int_pending[1]), 32'h0);
    clear(2'b01);
    chk("clr_pending0", 32'(bus.int_pending[0]), 32'h0);

    bus.int_raw = 2'b00;
    step(LAT + 2);
    chk("fall_no_event", 32'(bus.int_pending[0]), 32'h0);

`ifdef INT_COND_DEBOUNCE_EN
    // Three-cycle glitch must be rejected.
    bus.int_raw = 2'b01;
    step(3);
    bus.int_raw = 2'b00;
    step(10);
    chk("glitch_level",   32'(bus.int_level[0]),   32'h0);
    chk("glitch_pending", 32'(bus.int_pending[0]), 32'h0);
`else
    // A single sampled pulse passes straight through.
    bus.int_raw = 2'b01;
    step(1);
    bus.int_raw = 2'b00;
    step(LAT - 1);
    chk("pulse_pending", 32'(bus.int_pending[0]), 32'h1);
    step(4);
    clear(2'b01);
    chk("pulse_clr", 32'(bus.int_pending[0]), 32'h0);
`endif

    // Two rising edges on ch1 without clear set overrun.
    bus.int_raw = 2'b10;
    step(LAT + 1);
    chk("ch1_first_pending", 32'(bus.int_pending[1]), 32'h1);
    chk("ch1_first_overrun", 32'(bus.overrun[1]),     32'h0);
    bus.int_raw = 2'b00;
    step(LAT + 1);
    bus.int_raw = 2'b10;
    step(LAT + 1);
    chk("ch1_overrun", 32'(bus.overrun[1]),     32'h1);
    chk("ch1_pending", 32'(bus.int_pending[1]), 32'h1);
    chk("ch0_isolated", {30'd0, bus.overrun[0], bus.int_pending[0]}, 32'h0);
    clear(2'b10);
    chk("ch1_clr_pending", 32'(bus.int_pending[1]), 32'h0);
    chk("ch1_clr_overrun", 32'(bus.overrun[1]),     32'h0);

    // Clear coinciding with a new event on ch0.
    bus.edge_fall_en = 2'b01;
    bus.int_raw      = 2'b11;
    step(LAT);
    chk("coinc_setup", 32'(bus.int_pending[0]), 32'h1);
    bus.int_raw = 2'b10;
    step(LAT - 1);
    bus.int_clr = 2'b01;
    step(1);
    bus.int_clr = 2'b00;
    chk("coinc_pending", 32'(bus.int_pending[0]), 32'h1);
    chk("coinc_overrun", 32'(bus.overrun[0]),     32'h0);
    clear(2'b01);
    chk("coinc_cleanup", 32'(bus.int_pending[0]), 32'h0);

    // Fall-only enable on ch0.
    bus.edge_rise_en = 2'b10;
    bus.edge_fall_en = 2'b01;
    bus.int_raw      = 2'b11;
    step(LAT + 2);
    chk("fallonly_rise_level",   32'(bus.int_level[0]),   32'h1);
    chk("fallonly_rise_pending", 32'(bus.int_pending[0]), 32'h0);
    bus.int_raw = 2'b10;
    step(LAT - 1);
    chk("fallonly_early", 32'(bus.int_pending[0]), 32'h0);
    step(1);
    chk("fallonly_pending", 32'(bus.int_pending[0]), 32'h1);
    bus.edge_fall_en = 2'b00;
    step(2);
    chk("enable_off_keeps", 32'(bus.int_pending[0]), 32'h1);
    clear(2'b01);

    // Simultaneous rising events on both channels.
    bus.int_raw = 2'b00;
    step(LAT + 2);
    clear(2'b11);
    bus.edge_rise_en = 2'b11;
    bus.int_raw      = 2'b11;
    step(LAT - 1);
    chk("both_early", 32'(bus.int_pending), 32'h0);
    step(1);
    chk("both_pending", 32'(bus.int_pending), 32'h3);
    chk("both_overrun", 32'(bus.overrun),     32'h0);

    // Reset mid-activity with pins held high: one rise after full latency.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("rst_all_pending", 32'(bus.int_pending), 32'h0);
    chk("rst_all_level",   32'(bus.int_level),   32'h0);
    step(LAT - 1);
    chk("rst_held_early", 32'(bus.int_pending), 32'h0);
    step(1);
    chk("rst_held_rise", 32'(bus.int_pending), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
